// File: rtl/fifo_irq_pkg.sv
// Shared register map, response codes and FSM states
// for the FIFO interrupt AXI4-Lite register block.
package fifo_irq_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_ENABLE = 2'd1;
  localparam logic [1:0] REG_CLEAR  = 2'd2;
  localparam logic [1:0] REG_MASKED = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/fifo_irq_axil_regs.sv
// AXI4-Lite status/enable/clear/masked registers for the
// FIFO interrupt latch, with a registered masked irq line.
module fifo_irq_axil_regs
  import fifo_irq_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  input  logic                    irq_full,
  input  logic                    irq_empty,
  output logic                    irq_clear_full,
  output logic                    irq_clear_empty,
  output logic                    irq_out
);

  wr_state_e wst;
  rd_state_e rst_q;

  logic [ADDR_WIDTH-1:0] aw_q;
  logic [1:0]            wd_q;
  logic                  ws_q;
  logic [1:0]            enable;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  wr_go;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [1:0]            wr_bits;
  logic                  wr_strb;
  logic                  wr_ok;
  logic                  wr_hit;
  logic [1:0]            rd_bits;
  logic                  rd_ok;

  logic unused_bits;
  assign unused_bits = ^{s_wdata[DATA_WIDTH-1:2],
                         s_wstrb[DATA_WIDTH/8-1:1]};

  // Anything above the 16-byte window is a decode error.
  function automatic logic addr_ok(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a >> 4) == '0;
  endfunction

  always_comb begin
    aw_fire = s_awvalid && s_awready;
    w_fire  = s_wvalid && s_wready;
    wr_go   = 1'b0;
    wr_addr = s_awaddr;
    wr_bits = s_wdata[1:0];
    wr_strb = s_wstrb[0];
    unique case (wst)
      W_IDLE:    wr_go = aw_fire && w_fire;
      W_HAVE_AW: begin
        wr_go   = w_fire;
        wr_addr = aw_q;
      end
      W_HAVE_W:  begin
        wr_go   = aw_fire;
        wr_bits = wd_q;
        wr_strb = ws_q;
      end
      default:   wr_go = 1'b0;
    endcase
    wr_ok  = addr_ok(wr_addr);
    wr_hit = wr_go && wr_ok && wr_strb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wst       <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      aw_q      <= '0;
      wd_q      <= '0;
      ws_q      <= 1'b0;
    end else if (wr_go) begin
      wst       <= W_RESP;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b1;
      s_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      unique case (wst)
        W_IDLE: begin
          if (aw_fire) begin
            wst       <= W_HAVE_AW;
            aw_q      <= s_awaddr;
            s_awready <= 1'b0;
            s_wready  <= 1'b1;
          end else if (w_fire) begin
            wst       <= W_HAVE_W;
            wd_q      <= s_wdata[1:0];
            ws_q      <= s_wstrb[0];
            s_awready <= 1'b1;
            s_wready  <= 1'b0;
          end else begin
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            wst       <= W_IDLE;
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
          end
        end
        default: wst <= wst;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable          <= 2'b00;
      irq_clear_full  <= 1'b0;
      irq_clear_empty <= 1'b0;
      irq_out         <= 1'b0;
    end else begin
      irq_clear_full  <= wr_hit &&
        wr_addr[3:2] == REG_CLEAR && wr_bits[0];
      irq_clear_empty <= wr_hit &&
        wr_addr[3:2] == REG_CLEAR && wr_bits[1];
      if (wr_hit && wr_addr[3:2] == REG_ENABLE)
        enable <= wr_bits;
      irq_out <= |({irq_empty, irq_full} & enable);
    end
  end

  always_comb begin
    rd_ok   = addr_ok(s_araddr);
    rd_bits = 2'b00;
    unique case (s_araddr[3:2])
      REG_STATUS: rd_bits = {irq_empty, irq_full};
      REG_ENABLE: rd_bits = enable;
      REG_CLEAR:  rd_bits = 2'b00;
      REG_MASKED: rd_bits = {irq_empty, irq_full} & enable;
      default:    rd_bits = 2'b00;
    endcase
    if (!rd_ok)
      rd_bits = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q     <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      unique case (rst_q)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            rst_q     <= R_DATA;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            s_rdata   <= DATA_WIDTH'(rd_bits);
            s_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rst_q     <= R_IDLE;
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_irq_axil_regs.sv
// Scoreboard bench for fifo_irq_axil_regs with a behavioural
// register model and a simple upstream latch model.
module tb_fifo_irq_axil_regs;
  import fifo_irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [3:0]  s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic        irq_full = 1'b0;
  logic        irq_empty = 1'b0;
  logic        irq_clear_full;
  logic        irq_clear_empty;
  logic        irq_out;

  always #5 clk = ~clk;

  fifo_irq_axil_regs #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_awaddr(s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata(s_wdata),
    .s_wstrb(s_wstrb),
    .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp),
    .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .s_araddr(s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata(s_rdata),
    .s_rresp(s_rresp),
    .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .irq_full(irq_full),
    .irq_empty(irq_empty),
    .irq_clear_full(irq_clear_full),
    .irq_clear_empty(irq_clear_empty),
    .irq_out(irq_out)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_t;

  int tests = 0;
  int fails = 0;
  int exp_cf = 0;
  int exp_ce = 0;
  int seen_cf = 0;
  int seen_ce = 0;
  logic [1:0] model_en = 2'b00;
  logic set_full = 1'b0;
  logic set_empty = 1'b0;
  logic exp_cap = 1'b0;
  logic cap_v = 1'b0;
  rd_t rd_q[$];
  logic [1:0] b_q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout got none expected handshake",
             name);
  endtask

  function automatic rd_t model_read(input logic [3:0] a);
    rd_t r;
    logic [1:0] st;
    st = {irq_empty, irq_full};
    r.resp = RESP_OKAY;
    case (a / 4)
      0:       r.data = {30'd0, st};
      1:       r.data = {30'd0, model_en};
      2:       r.data = 32'd0;
      default: r.data = {30'd0, st & model_en};
    endcase
    return r;
  endfunction

  // Upstream latch: clear wins over set.
  always @(negedge clk) begin
    if (!rst_n) begin
      irq_full  = 1'b0;
      irq_empty = 1'b0;
    end else begin
      if (irq_clear_full) irq_full = 1'b0;
      else if (set_full)  irq_full = 1'b1;
      if (irq_clear_empty) irq_empty = 1'b0;
      else if (set_empty)  irq_empty = 1'b1;
    end
  end

  always @(posedge clk) begin
    cap_v   = rst_n;
    exp_cap = |({irq_empty, irq_full} & model_en);
  end

  always @(negedge clk) begin
    #1;
    if (irq_clear_full)  seen_cf++;
    if (irq_clear_empty) seen_ce++;
    if (rst_n && cap_v)
      check("irq_out", irq_out, exp_cap);
    if (s_bvalid && s_bready) begin
      if (b_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bresp_extra: got %0h expected none",
                 s_bresp);
      end else begin
        check("bresp", s_bresp, b_q.pop_front());
      end
    end
    if (s_rvalid && s_rready) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rdata_extra: got %0h expected none",
                 s_rdata);
      end else begin
        rd_t e;
        e = rd_q.pop_front();
        check("rdata", s_rdata, e.data);
        check("rresp", s_rresp, e.resp);
      end
    end
  end

  task automatic axi_write(input logic [3:0]  a,
                           input logic [31:0] d,
                           input logic [3:0]  strb,
                           input int aw_dly,
                           input int w_dly,
                           input int b_stall);
    logic [1:0] sel;
    int n;
    sel = a[3:2];
    b_q.push_back(RESP_OKAY);
    fork
      begin
        int k;
        k = 0;
        repeat (aw_dly) @(negedge clk);
        s_awaddr  = a;
        s_awvalid = 1'b1;
        while (!s_awready && k < 50) begin
          @(negedge clk);
          k++;
        end
        if (k >= 50) timeout("aw_handshake");
        @(negedge clk);
        s_awvalid = 1'b0;
      end
      begin
        int k;
        k = 0;
        repeat (w_dly) @(negedge clk);
        s_wdata  = d;
        s_wstrb  = strb;
        s_wvalid = 1'b1;
        while (!s_wready && k < 50) begin
          @(negedge clk);
          k++;
        end
        if (k >= 50) timeout("w_handshake");
        @(negedge clk);
        s_wvalid = 1'b0;
      end
    join
    check("bvalid_on_commit", s_bvalid, 1);
    check("clr_full_pulse", irq_clear_full,
          strb[0] && sel == 2 && d[0]);
    check("clr_empty_pulse", irq_clear_empty,
          strb[0] && sel == 2 && d[1]);
    if (strb[0]) begin
      if (sel == 1) model_en = d[1:0];
      if (sel == 2) begin
        exp_cf += int'(d[0]);
        exp_ce += int'(d[1]);
      end
    end
    n = 0;
    while (!s_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("bvalid");
    repeat (b_stall) begin
      check("bvalid_hold", s_bvalid, 1);
      check("bresp_hold", s_bresp, RESP_OKAY);
      @(negedge clk);
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a,
                          input int ar_dly,
                          input int r_stall);
    rd_t e;
    int k;
    k = 0;
    repeat (ar_dly) @(negedge clk);
    s_araddr  = a;
    s_arvalid = 1'b1;
    while (!s_arready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) timeout("ar_handshake");
    @(posedge clk);
    e = model_read(a);
    rd_q.push_back(e);
    @(negedge clk);
    s_arvalid = 1'b0;
    check("rvalid_latency", s_rvalid, 1);
    repeat (r_stall) begin
      check("rdata_hold", s_rdata, e.data);
      @(negedge clk);
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check("reset_ready_valid",
          {s_awready, s_wready, s_arready,
           s_bvalid, s_rvalid}, 0);
    check("reset_resp", {s_bresp, s_rresp}, 0);
    check("reset_rdata", s_rdata, 0);
    check("reset_irq",
          {irq_out, irq_clear_full, irq_clear_empty}, 0);
    rst_n = 1'b1;

    set_full = 1'b1;
    repeat (2) @(negedge clk);
    check("status_full_set", irq_full, 1);
    axi_read(4'h0, 0, 0);
    axi_write(4'h4, 32'h3, 4'hf, 0, 2, 0);
    @(negedge clk);
    check("irq_out_enabled", irq_out, 1);

    set_empty = 1'b1;
    @(negedge clk);
    set_empty = 1'b0;
    @(negedge clk);
    check("empty_latched", irq_empty, 1);
    axi_write(4'h8, 32'h2, 4'h1, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("empty_cleared", irq_empty, 0);
    axi_read(4'hC, 0, 1);

    axi_write(4'h4, 32'h0, 4'h0, 0, 0, 5);
    axi_read(4'h4, 0, 0);

    s_awaddr  = 4'h8;
    s_awvalid = 1'b1;
    k = 0;
    while (!s_awready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) timeout("aw_before_reset");
    @(negedge clk);
    s_awvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_en = 2'b00;
    #1;
    check("midreset_valids", {s_bvalid, s_rvalid}, 0);
    check("midreset_readies",
          {s_awready, s_wready, s_arready}, 0);
    check("midreset_irq",
          {irq_out, irq_clear_full, irq_clear_empty}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_pulse_on_reset", seen_cf + seen_ce,
          exp_cf + exp_ce);
    axi_read(4'h4, 0, 0);
    axi_write(4'h4, 32'h2, 4'hf, 1, 0, 0);
    fork
      axi_write(4'h4, 32'h1, 4'hf, 0, 0, 1);
      axi_read(4'hC, 1, 0);
    join

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      set_full  = 1'($urandom_range(0, 1));
      set_empty = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: axi_write(a, d, s, $urandom_range(0, 2),
                     $urandom_range(0, 2),
                     $urandom_range(0, 3));
        1: axi_read(a, $urandom_range(0, 2),
                    $urandom_range(0, 3));
        default: begin
          logic [3:0] ra;
          ra = 4'($urandom_range(0, 15));
          fork
            axi_write(a, d, s, $urandom_range(0, 2),
                      $urandom_range(0, 2),
                      $urandom_range(0, 2));
            axi_read(ra, $urandom_range(0, 2),
                     $urandom_range(0, 2));
          join
        end
      endcase
    end

    repeat (4) @(negedge clk);
    check("clear_full_count", seen_cf, exp_cf);
    check("clear_empty_count", seen_ce, exp_ce);
    check("b_queue_drained", b_q.size(), 0);
    check("r_queue_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
